store_merge_unit: RTL and testbench
===================================

Name: store_merge_unit

Overview:
Parametrised store-size engine that executes sw/sh/sb against a word-wide data memory.
- Word stores are written directly.
- Halfword and byte stores run a read-modify-write: fetch the memory word, insert the source lanes at the address-selected position, write the result back.
- Sits between the control unit (store request) and the data memory port.
- Adds multi-cycle handshaking, lane selection by address and alignment checking.

Parameters:
DATA_W, 32, memory word width in bits; power of two, >= 32
ADDR_W, 32, byte address width
OFF_W, $clog2(DATA_W/8), byte-offset bits inside a word (derived, localparam)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  store request, sampled only in IDLE
size  in  2  01 word, 10 halfword, 11 byte, 00 reserved
addr  in  ADDR_W  byte address of the store
wdata  in  DATA_W  source register value (b); byte/half taken from the low bits
busy  out  1  high from the cycle after an accepted start until return to IDLE
done  out  1  one-cycle pulse, store completed
err  out  1  one-cycle pulse, store rejected; no memory access made
mem_addr  out  ADDR_W  word-aligned address (offset bits forced to 0)
mem_rd  out  1  read request, held until mem_ready
mem_wr  out  1  write request, held until mem_ready
mem_wdata  out  DATA_W  merged write data
mem_rdata  in  DATA_W  read data, valid when mem_ready is high during a read
mem_ready  in  1  memory handshake completion

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, err, mem_rd, mem_wr = 0; mem_addr, mem_wdata and internal data/offset/size latches = 0.
- Capture: on start in IDLE, latch size, addr and wdata. Later changes to these inputs have no effect on the operation in progress.
- start while not IDLE is ignored; it is not queued.
- Alignment checks, made at start:
  - size 01 requires addr[OFF_W-1:0]==0.
  - size 10 requires addr[0]==0.
  - size 00 is always an error.
  - On failure: next state ERR; err pulses for exactly one cycle; back to IDLE.
- States: IDLE, RD, MERGE, WR, DONE, ERR.
  - IDLE -> WR for a valid word store; mem_wdata=wdata.
  - IDLE -> RD for a valid half/byte store.
  - RD: mem_rd=1, mem_addr valid. On mem_ready, capture mem_rdata -> MERGE.
  - MERGE (one cycle): build the merged word.
    - byte: lane addr[OFF_W-1:0] <= wdata[7:0].
    - half: 16-bit lane addr[OFF_W-1:1] <= wdata[15:0].
    - All other bits are taken from the captured read data.
    - Next state WR.
  - WR: mem_wr=1; mem_wdata stable. On mem_ready -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- mem_rd and mem_wr are never high in the same cycle.
- mem_ready outside RD/WR is ignored.
- Latency with mem_ready high on the first cycle of each request, counting start at cycle 0:
  - word: done at cycle 3.
  - half/byte: done at cycle 5.
  - Each extra memory wait cycle adds 1.
- No timeout: RD/WR wait indefinitely.
- Lanes are little-endian: lane 0 = bits [7:0].
- Reset asserted mid-RD or mid-WR drops the request immediately. No partial write is signalled.

Optional Feature:
STORE_MERGE_BYTE_EN_EN
- Defined:
  - Adds output port mem_be [DATA_W/8-1:0].
  - Half/byte stores skip RD/MERGE: IDLE -> WR directly.
  - mem_wdata carries the source lanes replicated across the word.
  - mem_be marks only the target lanes; word stores set all ones.
  - Latency for every size is 3 cycles.
  - mem_be resets to 0.
- Undefined:
  - No mem_be port.
  - Read-modify-write exactly as described above.

Test Plan:
- Word store, DATA_W=32: addr=0x100, wdata=0xDEADBEEF, mem_ready tied 1 -> mem_wr with mem_addr=0x100, mem_wdata=0xDEADBEEF; done at cycle 3; mem_rd never asserted.
- Byte store: addr=0x203, wdata=0x000000AB, mem_rdata=0x11223344 -> mem_rd at 0x200, then mem_wdata=0xAB223344; done at cycle 5.
- Halfword store with wait states: addr=0x302, wdata=0x0000CAFE, mem_rdata=0x55667788, mem_ready delayed 2 cycles on both RD and WR -> mem_wdata=0xCAFE7788; done at cycle 9; busy high cycles 1..8.
- Misalignment: size=10 with addr=0x101; size=01 with addr=0x102; size=00 -> err pulses one cycle each; mem_rd and mem_wr stay 0; done stays 0.
- Reset mid-operation: assert reset_n=0 while in RD with mem_ready=0 -> mem_rd drops asynchronously; after release, busy=0; a new word store then completes normally.
- DATA_W=64, byte store: addr=0x1007, wdata=0x5A, mem_rdata=0 -> mem_addr=0x1000, mem_wdata=0x5A00000000000000. With STORE_MERGE_BYTE_EN_EN defined -> no read, mem_be=0x80, done at cycle 3.

Source files
------------

// File: rtl/store_merge_unit.sv
// Store-size engine: word stores write straight through, half/byte stores read-modify-write.
// Define STORE_MERGE_BYTE_EN_EN to replace read-modify-write with byte-enabled direct writes (adds mem_be).
module store_merge_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef STORE_MERGE_BYTE_EN_EN
    ,
    output logic [DATA_W/8-1:0] mem_be
`endif
);

    localparam int OFF_W = $clog2(DATA_W/8);
    localparam int LANES = DATA_W/8;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_MERGE, S_WR, S_DONE, S_ERR} state_e;
    typedef enum logic [1:0] {
        SZ_RSV  = 2'b00,
        SZ_WORD = 2'b01,
        SZ_HALF = 2'b10,
        SZ_BYTE = 2'b11
    } size_e;

    state_e            state;
    size_e             size_in;
    size_e             size_q;
    logic [OFF_W-1:0]  off_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              misaligned;
    logic [DATA_W-1:0] merged;

    assign size_in = size_e'(size);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        misaligned = 1'b0;
        case (size_in)
            SZ_WORD: misaligned = |addr[OFF_W-1:0];
            SZ_HALF: misaligned = addr[0];
            SZ_BYTE: misaligned = 1'b0;
            default: misaligned = 1'b1;
        endcase
    end

    // Insert the source lanes into the captured read word; lane 0 is bits [7:0].
    always_comb begin
        merged = rdata_q;
        case (size_q)
            SZ_BYTE: merged[{off_q, 3'b000} +: 8]               = wdata_q[7:0];
            SZ_HALF: merged[{off_q[OFF_W-1:1], 4'b0000} +: 16] = wdata_q[15:0];
            default: ;
        endcase
    end

`ifdef STORE_MERGE_BYTE_EN_EN
    logic [DATA_W-1:0] bcast;
    logic [LANES-1:0]  be_next;

    always_comb begin
        bcast   = wdata;
        be_next = '1;
        case (size_in)
            SZ_BYTE: begin
                bcast   = {LANES{wdata[7:0]}};
                be_next = {{(LANES-1){1'b0}}, 1'b1} << addr[OFF_W-1:0];
            end
            SZ_HALF: begin
                bcast   = {(LANES/2){wdata[15:0]}};
                be_next = {{(LANES-2){1'b0}}, 2'b11} << {addr[OFF_W-1:1], 1'b0};
            end
            default: ;
        endcase
    end
`endif

    // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: datapath latches are reset along with control, so the reset state is fully defined.
            state     <= S_IDLE;
            size_q    <= SZ_RSV;
            off_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
`ifdef STORE_MERGE_BYTE_EN_EN
            mem_be    <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        size_q   <= size_in;
                        off_q    <= addr[OFF_W-1:0];
                        wdata_q  <= wdata;
                        mem_addr <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        busy     <= 1'b1;
                        if (misaligned) begin
                            state <= S_ERR;
`ifdef STORE_MERGE_BYTE_EN_EN
                        end else begin
                            state     <= S_WR;
                            mem_wr    <= 1'b1;
                            mem_wdata <= bcast;
                            mem_be    <= be_next;
                        end
`else
                        end else if (size_in == SZ_WORD) begin
                            state     <= S_WR;
                            mem_wr    <= 1'b1;
                            mem_wdata <= wdata;
                        end else begin
                            state  <= S_RD;
                            mem_rd <= 1'b1;
                        end
`endif
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        rdata_q <= mem_rdata;
                        mem_rd  <= 1'b0;
                        state   <= S_MERGE;
                    end
                end
                S_MERGE: begin
                    mem_wdata <= merged;
                    mem_wr    <= 1'b1;
                    state     <= S_WR;
                end
                S_WR: begin
                    if (mem_ready) begin
                        mem_wr <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    busy  <= 1'b0;
                    err   <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: 32-bit and 64-bit instances, directed cases plus randomized stores
// checked against a byte-lane reference model; follows STORE_MERGE_BYTE_EN_EN when defined.
module tb_store_merge_unit;

    localparam int AW = 32;
`ifdef STORE_MERGE_BYTE_EN_EN
    localparam bit BE_MODE = 1'b1;
`else
    localparam bit BE_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [AW-1:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [63:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    logic        b32, d32, e32, rd32, wr32, b64, d64, e64, rd64, wr64;
    logic [AW-1:0] a32, a64;
    logic [31:0] wd32;
    logic [63:0] wd64;
    logic [3:0]  be32;
    logic [7:0]  be64;
    logic        start32, start64, ready32, ready64;

    logic        o_busy, o_done, o_err, o_rd, o_wr;
    logic [AW-1:0] o_addr;
    logic [63:0] o_wdata;
    logic [7:0]  o_be;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign start32 = start & ~sel;
    assign start64 = start & sel;
    assign ready32 = mem_ready & ~sel;
    assign ready64 = mem_ready & sel;

    store_merge_unit #(.DATA_W(32), .ADDR_W(AW)) dut32 (
        .clk(clk), .reset_n(reset_n), .start(start32), .size(size), .addr(addr),
        .wdata(wdata[31:0]), .busy(b32), .done(d32), .err(e32), .mem_addr(a32),
        .mem_rd(rd32), .mem_wr(wr32), .mem_wdata(wd32), .mem_rdata(mem_rdata[31:0]),
        .mem_ready(ready32)
`ifdef STORE_MERGE_BYTE_EN_EN
        , .mem_be(be32)
`endif
    );

    store_merge_unit #(.DATA_W(64), .ADDR_W(AW)) dut64 (
        .clk(clk), .reset_n(reset_n), .start(start64), .size(size), .addr(addr),
        .wdata(wdata), .busy(b64), .done(d64), .err(e64), .mem_addr(a64),
        .mem_rd(rd64), .mem_wr(wr64), .mem_wdata(wd64), .mem_rdata(mem_rdata),
        .mem_ready(ready64)
`ifdef STORE_MERGE_BYTE_EN_EN
        , .mem_be(be64)
`endif
    );

`ifndef STORE_MERGE_BYTE_EN_EN
    assign be32 = '0;
    assign be64 = '0;
`endif

    always_comb begin
        o_busy  = sel ? b64  : b32;
        o_done  = sel ? d64  : d32;
        o_err   = sel ? e64  : e32;
        o_rd    = sel ? rd64 : rd32;
        o_wr    = sel ? wr64 : wr32;
        o_addr  = sel ? a64  : a32;
        o_wdata = sel ? wd64 : {32'h0, wd32};
        o_be    = sel ? be64 : {4'h0, be32};
    end

    typedef struct {
        int          done_cyc;
        int          err_cyc;
        int          n_done;
        int          n_err;
        int          rd_cycles;
        int          wr_cycles;
        int          busy_first;
        int          busy_last;
        int          busy_cnt;
        logic [31:0] rd_addr;
        logic [31:0] wr_addr;
        logic [63:0] wr_data;
        logic [7:0]  wr_be;
        logic        wr_unstable;
        logic        overlap;
        logic        timeout;
    } obs_t;

    // ---------------- reference model (byte lanes, little-endian) ----------------
    function automatic bit exp_misaligned(int dw, logic [1:0] sz, logic [31:0] a);
        int off = int'(a % (dw / 8));
        return (sz == 2'b00) || (sz == 2'b01 && off != 0) || (sz == 2'b10 && a[0]);
    endfunction

    function automatic logic [63:0] exp_data(int dw, logic [1:0] sz, logic [31:0] a,
                                             logic [63:0] wd, logic [63:0] rdd);
        logic [7:0]  b [8];
        logic [63:0] r = '0;
        int off  = int'(a % (dw / 8));
        int hoff = off - (off % 2);
        for (int i = 0; i < 8; i++) b[i] = rdd[8*i +: 8];
        for (int i = 0; i < dw / 8; i++) begin
            if (sz == 2'b01)      b[i] = wd[8*i +: 8];
            else if (BE_MODE)     b[i] = (sz == 2'b11) ? wd[7:0] : ((i % 2) ? wd[15:8] : wd[7:0]);
        end
        if (!BE_MODE && sz == 2'b11) b[off] = wd[7:0];
        if (!BE_MODE && sz == 2'b10) begin
            b[hoff]     = wd[7:0];
            b[hoff + 1] = wd[15:8];
        end
        for (int i = 0; i < dw / 8; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    function automatic logic [7:0] exp_be(int dw, logic [1:0] sz, logic [31:0] a);
        int off = int'(a % (dw / 8));
        if (sz == 2'b11) return 8'(1 << off);
        if (sz == 2'b10) return 8'(3 << (off - (off % 2)));
        return 8'((1 << (dw / 8)) - 1);
    endfunction

    function automatic int exp_latency(logic [1:0] sz, int rw, int ww);
        if (BE_MODE || sz == 2'b01) return 3 + ww;
        return 5 + rw + ww;
    endfunction

    // ---------------- transaction driver / memory responder ----------------
    task automatic do_store(input logic s, input logic [1:0] sz, input logic [31:0] a,
                            input logic [63:0] wd, input logic [63:0] rdd,
                            input int rw, input int ww, output obs_t o);
        int fin = -1;
        o = '{default: 0};
        o.done_cyc = -1;
        o.err_cyc = -1;
        o.busy_first = -1;
        @(negedge clk);
        sel = s; size = sz; addr = a; wdata = wd; start = 1'b1; mem_ready = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            size  = 2'($urandom);
            addr  = $urandom;
            wdata = {$urandom, $urandom};
            start = o_busy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (o_busy) begin
                if (o.busy_first < 0) o.busy_first = c;
                o.busy_cnt++;
                o.busy_last = c;
            end
            if (o_done) begin o.n_done++; if (o.done_cyc < 0) o.done_cyc = c; end
            if (o_err)  begin o.n_err++;  if (o.err_cyc < 0)  o.err_cyc = c;  end
            if (o_rd && o_wr) o.overlap = 1'b1;
            mem_ready = 1'b0;
            mem_rdata = {$urandom, $urandom};
            if (o_rd) begin
                o.rd_cycles++;
                o.rd_addr = o_addr;
                if (o.rd_cycles > rw) begin mem_ready = 1'b1; mem_rdata = rdd; end
            end else if (o_wr) begin
                if (o.wr_cycles > 0 && (o_wdata !== o.wr_data || o_addr !== o.wr_addr))
                    o.wr_unstable = 1'b1;
                o.wr_cycles++;
                o.wr_addr = o_addr;
                o.wr_data = o_wdata;
                o.wr_be   = o_be;
                if (o.wr_cycles > ww) mem_ready = 1'b1;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            if (fin < 0 && (o_done || o_err)) fin = c;
            if (fin >= 0 && c >= fin + 2) break;
        end
        if (fin < 0) o.timeout = 1'b1;
        start = 1'b0;
        mem_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({b32, d32, e32, rd32, wr32, b64, d64, e64, rd64, wr64} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b expected 0", {b32, d32, e32, rd32, wr32, b64, d64, e64, rd64, wr64});
        end
        n_cmp++;
        if ({a32, a64, wd32, wd64, be32, be64} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: addr %0h/%0h wdata %0h/%0h be %0h/%0h expected all 0", a32, a64, wd32, wd64, be32, be64);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({b32, rd32, wr32, b64, rd64, wr64} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_release: got %b expected 0", {b32, rd32, wr32, b64, rd64, wr64});
        end
    endtask

    task automatic test_word();
        obs_t o;
        do_store(1'b0, 2'b01, 32'h100, 64'hDEADBEEF, 64'h0, 0, 0, o);
        n_cmp++;
        if (o.done_cyc !== 3) begin n_bad++; $display("FAIL word_done_cyc: got %0d expected 3", o.done_cyc); end
        n_cmp++;
        if (o.wr_addr !== 32'h100 || o.wr_data !== 64'hDEADBEEF) begin
            n_bad++; $display("FAIL word_write: got addr %0h data %0h expected 100 deadbeef", o.wr_addr, o.wr_data);
        end
        n_cmp++;
        if (o.rd_cycles !== 0) begin n_bad++; $display("FAIL word_no_read: got %0d read cycles expected 0", o.rd_cycles); end
    endtask

    task automatic test_byte();
        obs_t o;
        do_store(1'b0, 2'b11, 32'h203, 64'hAB, 64'h11223344, 0, 0, o);
        n_cmp++;
        if (o.done_cyc !== (BE_MODE ? 3 : 5)) begin
            n_bad++; $display("FAIL byte_done_cyc: got %0d expected %0d", o.done_cyc, BE_MODE ? 3 : 5);
        end
        n_cmp++;
        if (o.wr_data !== (BE_MODE ? 64'hABABABAB : 64'hAB223344)) begin
            n_bad++; $display("FAIL byte_wdata: got %0h expected %0h", o.wr_data, BE_MODE ? 64'hABABABAB : 64'hAB223344);
        end
        n_cmp++;
        if (o.rd_cycles !== (BE_MODE ? 0 : 1) || (!BE_MODE && o.rd_addr !== 32'h200)) begin
            n_bad++; $display("FAIL byte_read: got %0d cycles at %0h expected %0d at 200", o.rd_cycles, o.rd_addr, BE_MODE ? 0 : 1);
        end
        if (BE_MODE) begin
            n_cmp++;
            if (o.wr_be !== 8'h08) begin n_bad++; $display("FAIL byte_be: got %0h expected 08", o.wr_be); end
        end
    endtask

    task automatic test_half_wait();
        obs_t o;
        int lat = BE_MODE ? 5 : 9;
        do_store(1'b0, 2'b10, 32'h302, 64'hCAFE, 64'h55667788, 2, 2, o);
        n_cmp++;
        if (o.done_cyc !== lat) begin n_bad++; $display("FAIL half_done_cyc: got %0d expected %0d", o.done_cyc, lat); end
        n_cmp++;
        if (o.wr_data !== (BE_MODE ? 64'hCAFECAFE : 64'hCAFE7788)) begin
            n_bad++; $display("FAIL half_wdata: got %0h expected %0h", o.wr_data, BE_MODE ? 64'hCAFECAFE : 64'hCAFE7788);
        end
        n_cmp++;
        if (o.busy_first !== 1 || o.busy_last !== lat - 1 || o.busy_cnt !== lat - 1) begin
            n_bad++; $display("FAIL half_busy: got cycles %0d..%0d count %0d expected 1..%0d", o.busy_first, o.busy_last, o.busy_cnt, lat - 1);
        end
        n_cmp++;
        if (o.wr_cycles !== 3 || o.wr_unstable !== 1'b0 || o.overlap !== 1'b0) begin
            n_bad++; $display("FAIL half_wr_hold: got %0d cycles unstable %b overlap %b expected 3 0 0", o.wr_cycles, o.wr_unstable, o.overlap);
        end
    endtask

    task automatic test_misalign();
        obs_t o;
        logic [1:0]  szs [3] = '{2'b10, 2'b01, 2'b00};
        logic [31:0] ads [3] = '{32'h101, 32'h102, 32'h100};
        for (int i = 0; i < 3; i++) begin
            do_store(1'b0, szs[i], ads[i], 64'hFFFF_FFFF, 64'h0, 0, 0, o);
            n_cmp++;
            if (o.err_cyc !== 2 || o.n_err !== 1) begin
                n_bad++; $display("FAIL misalign_err[%0d]: got cycle %0d count %0d expected 2 1", i, o.err_cyc, o.n_err);
            end
            n_cmp++;
            if (o.rd_cycles !== 0 || o.wr_cycles !== 0 || o.n_done !== 0) begin
                n_bad++; $display("FAIL misalign_quiet[%0d]: got rd %0d wr %0d done %0d expected 0 0 0", i, o.rd_cycles, o.wr_cycles, o.n_done);
            end
        end
    endtask

    task automatic test_wide64();
        obs_t o;
        do_store(1'b1, 2'b11, 32'h1007, 64'h5A, 64'h0, 0, 0, o);
        n_cmp++;
        if (o.wr_addr !== 32'h1000 || o.wr_data !== (BE_MODE ? 64'h5A5A5A5A5A5A5A5A : 64'h5A00000000000000)) begin
            n_bad++; $display("FAIL wide_write: got addr %0h data %0h", o.wr_addr, o.wr_data);
        end
        n_cmp++;
        if (o.done_cyc !== (BE_MODE ? 3 : 5)) begin
            n_bad++; $display("FAIL wide_done_cyc: got %0d expected %0d", o.done_cyc, BE_MODE ? 3 : 5);
        end
        n_cmp++;
        if (BE_MODE ? (o.rd_cycles !== 0 || o.wr_be !== 8'h80) : (o.rd_addr !== 32'h1000)) begin
            n_bad++; $display("FAIL wide_rd_be: got rd %0d at %0h be %0h", o.rd_cycles, o.rd_addr, o.wr_be);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit   seen = 1'b0;
        @(negedge clk);
        sel = 1'b0; size = 2'b10; addr = 32'h402; wdata = 64'h1234; start = 1'b1; mem_ready = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            mem_ready = 1'b0;
            if (o_rd || o_wr) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL rmid_request: got no request expected one within 10 cycles"); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_rd, o_wr, o_busy} !== 3'b000 || o_addr !== '0) begin
            n_bad++; $display("FAIL rmid_async_drop: got rd/wr/busy %b addr %0h expected 000 0", {o_rd, o_wr, o_busy}, o_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_bad++; $display("FAIL rmid_idle: got busy %b done %b expected 0 0", o_busy, o_done);
        end
        do_store(1'b0, 2'b01, 32'h80, 64'hA5A50F0F, 64'h0, 0, 0, o);
        n_cmp++;
        if (o.done_cyc !== 3 || o.wr_data !== 64'hA5A50F0F || o.wr_addr !== 32'h80) begin
            n_bad++; $display("FAIL rmid_recover: got done %0d data %0h addr %0h expected 3 a5a50f0f 80", o.done_cyc, o.wr_data, o.wr_addr);
        end
    endtask

    task automatic test_random();
        obs_t o;
        for (int t = 0; t < 60; t++) begin
            logic        s   = 1'($urandom_range(0, 1));
            int          dw  = s ? 64 : 32;
            logic [1:0]  sz  = 2'($urandom_range(0, 3));
            logic [31:0] a   = $urandom & 32'hFFFF;
            logic [63:0] wd  = {$urandom, $urandom};
            logic [63:0] rdd = {$urandom, $urandom};
            int          rw  = $urandom_range(0, 3);
            int          ww  = $urandom_range(0, 3);
            int          lat = exp_latency(sz, rw, ww);
            logic [63:0] ed  = exp_data(dw, sz, a, wd, rdd);
            logic [31:0] ea  = a & ~32'(dw / 8 - 1);
            bit          rmw = !BE_MODE && sz != 2'b01;
            if (dw == 32) rdd[63:32] = 32'h0;
            ed = exp_data(dw, sz, a, wd, rdd);
            do_store(s, sz, a, wd, rdd, rw, ww, o);
            if (exp_misaligned(dw, sz, a)) begin
                n_cmp++;
                if (o.err_cyc !== 2 || o.n_err !== 1 || o.n_done !== 0 || o.rd_cycles !== 0 || o.wr_cycles !== 0) begin
                    n_bad++; $display("FAIL rand_err[%0d]: got err %0d/%0d done %0d rd %0d wr %0d expected err at 2, no access", t, o.err_cyc, o.n_err, o.n_done, o.rd_cycles, o.wr_cycles);
                end
            end else begin
                n_cmp++;
                if (o.done_cyc !== lat || o.n_done !== 1 || o.n_err !== 0) begin
                    n_bad++; $display("FAIL rand_latency[%0d]: got done %0d count %0d err %0d expected %0d 1 0", t, o.done_cyc, o.n_done, o.n_err, lat);
                end
                n_cmp++;
                if (o.wr_data !== ed || o.wr_addr !== ea) begin
                    n_bad++; $display("FAIL rand_write[%0d]: got %0h @%0h expected %0h @%0h", t, o.wr_data, o.wr_addr, ed, ea);
                end
                n_cmp++;
                if (o.rd_cycles !== (rmw ? rw + 1 : 0) || (rmw && o.rd_addr !== ea) || o.wr_cycles !== ww + 1) begin
                    n_bad++; $display("FAIL rand_handshake[%0d]: got rd %0d @%0h wr %0d expected rd %0d wr %0d", t, o.rd_cycles, o.rd_addr, o.wr_cycles, rmw ? rw + 1 : 0, ww + 1);
                end
                n_cmp++;
                if (o.overlap !== 1'b0 || o.wr_unstable !== 1'b0 || o.busy_first !== 1 || o.busy_cnt !== lat - 1) begin
                    n_bad++; $display("FAIL rand_busy[%0d]: got overlap %b unstable %b busy %0d x%0d expected 0 0 1 x%0d", t, o.overlap, o.wr_unstable, o.busy_first, o.busy_cnt, lat - 1);
                end
                if (BE_MODE) begin
                    n_cmp++;
                    if (o.wr_be !== exp_be(dw, sz, a)) begin
                        n_bad++; $display("FAIL rand_be[%0d]: got %0h expected %0h", t, o.wr_be, exp_be(dw, sz, a));
                    end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half_wait();
        test_misalign();
        test_wide64();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
